// File: rtl/issueq_lane_arbiter.sv
// Round-robin arbiter that picks one ready issue-queue entry per cycle for a single issue lane.
// Grants are registered, held under back-pressure, and counted with a saturating statistic.
module issueq_lane_arbiter #(
  parameter int NUM_REQ = 16,
  parameter int IDX_W   = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] request_i,
  input  logic               stall_i,
  input  logic               flush_i,
  output logic               grantValid_o,
  output logic [IDX_W-1:0]   grantIdx_o,
  output logic [NUM_REQ-1:0] grantOneHot_o,
  output logic [CNT_W-1:0]   grantCount_o
);

  logic [IDX_W-1:0]   rr_ptr_p1;
  logic               fresh_p1;
  logic               vld_p1;
  logic [IDX_W-1:0]   idx_p1;
  logic [NUM_REQ-1:0] onehot_p1;
  logic [CNT_W-1:0]   cnt_p1;

  logic [NUM_REQ-1:0] last_grant_p0;
  logic [NUM_REQ-1:0] cand_p0;
  logic               hit_p0;
  logic [IDX_W-1:0]   sel_idx_p0;
  logic [IDX_W-1:0]   probe_p0;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    if (&cnt) return cnt;
    return cnt + CNT_W'(1);
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot_of(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

  // ---- p0: candidate masking and rotating priority search ----
  // Only a grant issued in the previous cycle is masked; one that was held
  // under stall already had its clear window, so it may compete again.
  assign last_grant_p0 = (vld_p1 && fresh_p1) ? onehot_p1 : '0;
  assign cand_p0       = request_i & ~last_grant_p0;

  always_comb begin
    hit_p0     = 1'b0;
    sel_idx_p0 = '0;
    probe_p0   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      probe_p0 = rr_ptr_p1 + IDX_W'(i);
      if (!hit_p0 && cand_p0[probe_p0]) begin
        hit_p0     = 1'b1;
        sel_idx_p0 = probe_p0;
      end
    end
  end

  // ---- p1: registered grant, pointer and statistics ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_p1 <= '0;
      fresh_p1  <= 1'b0;
      vld_p1    <= 1'b0;
      idx_p1    <= '0;
      onehot_p1 <= '0;
      cnt_p1    <= '0;
    end else if (flush_i) begin
      rr_ptr_p1 <= '0;
      fresh_p1  <= 1'b0;
      vld_p1    <= 1'b0;
      onehot_p1 <= '0;
    end else if (stall_i) begin
      fresh_p1  <= 1'b0;
    end else if (hit_p0) begin
      rr_ptr_p1 <= sel_idx_p0 + IDX_W'(1);
      fresh_p1  <= 1'b1;
      vld_p1    <= 1'b1;
      idx_p1    <= sel_idx_p0;
      onehot_p1 <= onehot_of(sel_idx_p0);
      cnt_p1    <= sat_inc(cnt_p1);
    end else begin
      fresh_p1  <= 1'b0;
      vld_p1    <= 1'b0;
      onehot_p1 <= '0;
    end
  end

  assign grantValid_o  = vld_p1;
  assign grantIdx_o    = idx_p1;
  assign grantOneHot_o = onehot_p1;
  assign grantCount_o  = cnt_p1;

endmodule

// File: doc/issueq_lane_arbiter.md
ISSUEQ_LANE_ARBITER -- requirements
Module: issueq_lane_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 16, number of issue-queue entries competing for one issue lane (power of two, 4..64).
REQ-002 SHALL have parameter IDX_W, default 4, equal to log2(NUM_REQ).
REQ-003 SHALL have parameter CNT_W, default 16, width of the grant statistics counter.
REQ-004 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port request_i  input  NUM_REQ  per-entry ready-to-issue flags; bit k means entry k requests this lane.
REQ-007 SHALL have port stall_i  input  1  register-read back-pressure; high means the downstream latch cannot accept a grant this cycle.
REQ-008 SHALL have port flush_i  input  1  mispredict/recovery flush of this lane.
REQ-009 SHALL have port grantValid_o  output  1  registered; a grant is presented this cycle.
REQ-010 SHALL have port grantIdx_o  output  IDX_W  registered; encoded index of the granted entry.
REQ-011 SHALL have port grantOneHot_o  output  NUM_REQ  registered; one-hot form of grantIdx_o, all-zero when grantValid_o is 0.
REQ-012 SHALL have port grantCount_o  output  CNT_W  registered; saturating count of grants issued since reset.

Function
REQ-013 SHALL keep a round-robin pointer rr_ptr (IDX_W bits) naming the highest-priority entry.
REQ-014 SHALL form the candidate vector as request_i AND NOT lastGrant, where lastGrant is grantOneHot_o when grantValid_o=1 and all-zero otherwise (masks the entry granted last cycle, whose issue-queue clear lands one cycle late).
REQ-015 SHALL select the first set candidate bit at index rr_ptr, rr_ptr+1, ... wrapping modulo NUM_REQ.
REQ-016 SHALL, on a cycle with flush_i=0, stall_i=0 and a nonzero candidate vector, register grantValid_o=1, grantIdx_o=selected index, grantOneHot_o=1<<selected index, with latency 1 cycle from request_i.
REQ-017 SHALL, in the same case, set rr_ptr to (selected index + 1) mod NUM_REQ, wrapping NUM_REQ-1 to 0.
REQ-018 SHALL, in the same case, increment grantCount_o by 1, holding at 2^CNT_W-1 once reached (no wrap).
REQ-019 SHALL, on a cycle with flush_i=0, stall_i=0 and an all-zero candidate vector, register grantValid_o=0 and grantOneHot_o=0, hold grantIdx_o, rr_ptr and grantCount_o.
REQ-020 SHALL, on a cycle with flush_i=0 and stall_i=1, hold grantValid_o, grantIdx_o, grantOneHot_o, rr_ptr and grantCount_o unchanged (grant re-presented until accepted).
REQ-021 SHALL, while a grant is held under stall, not apply the REQ-014 mask a second time; masking uses only the grant registered in the immediately preceding cycle.
REQ-022 SHALL, on flush_i=1, register grantValid_o=0, grantOneHot_o=0, rr_ptr=0, holding grantIdx_o and grantCount_o; flush overrides stall_i and request_i.
REQ-023 SHALL never assert grantValid_o for an entry whose request_i bit was 0 in the selecting cycle.
REQ-024 SHALL contain no combinational path from any input to any output.

Reset
REQ-025 SHALL, while reset=1, asynchronously force grantValid_o=0, grantIdx_o=0, grantOneHot_o=0, grantCount_o=0, rr_ptr=0.
REQ-026 SHALL, on reset asserted mid-stall or mid-grant, drop the held grant immediately and resume REQ-016 selection on the first rising edge after reset deasserts, starting at entry 0.

Verification
REQ-027 Bench SHALL cover: after reset, request_i=0x0011 steady, no stall -> grants idx 0,4,0,4,... on consecutive cycles, grantCount_o=1,2,3,...
REQ-028 Bench SHALL cover: request_i=0x8000 only, rr_ptr=0 -> grant idx 15, rr_ptr wraps to 0; next cycle idx 15 masked -> grantValid_o=0; following cycle idx 15 granted again.
REQ-029 Bench SHALL cover: grant idx 3 registered, stall_i=1 for 3 cycles with request_i changing -> grantValid_o=1, grantIdx_o=3 held all 3 cycles, grantCount_o unchanged.
REQ-030 Bench SHALL cover: flush_i=1 together with stall_i=1 and request_i=0xFFFF -> next cycle grantValid_o=0, grantOneHot_o=0; following cycle (no flush) grant idx 0.
REQ-031 Bench SHALL cover: CNT_W=4, request_i=0xFFFF for 20 cycles -> grantCount_o saturates at 15 and stays 15.
REQ-032 Bench SHALL cover: reset pulsed asynchronously between edges during a held grant -> grantValid_o=0 and grantCount_o=0 before the next clock edge.
